// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses, and a selectable standard or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Wr_en,
  input  logic [DATA_W-1:0]         Data_in,
  input  logic                      Rd_en,
  output logic [DATA_W-1:0]         Data_out,
  output logic                      Full,
  output logic                      Empty,
  output logic                      Almost_full,
  output logic                      Almost_empty,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance looks only at the registered flags, so a read never frees a slot
  // for a write in the same cycle when full.
  assign wr_acc = Wr_en & ~Full;
  assign rd_acc = Rd_en & ~Empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg     <= count_reg + CW'(wr_acc) - CW'(rd_acc);
      overflow_reg  <= Wr_en & Full;
      underflow_reg <= Rd_en & Empty;
    end
  end

  // Storage is never cleared; the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr_reg] <= Data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign Data_out = mem[rd_ptr_reg];
    end else begin : g_std
      logic [DATA_W-1:0] data_out_reg;
      always_ff @(posedge clk) begin
        if (reset)       data_out_reg <= '0;
        else if (rd_acc) data_out_reg <= mem[rd_ptr_reg];
      end
      assign Data_out = data_out_reg;
    end
  endgenerate

  assign Count        = count_reg;
  assign Full         = (count_reg == FULL_C);
  assign Empty        = (count_reg == '0);
  assign Almost_full  = (count_reg >= AF_C);
  assign Almost_empty = (count_reg <= AE_C);
  assign Overflow     = overflow_reg;
  assign Underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance checked through a read-data
// scoreboard, plus a first-word-fall-through instance for head visibility and mid-fill reset.
module tb_sync_fifo_param;

  logic       clk;
  logic       reset, wr_en, rd_en;
  logic [3:0] data_in, data_out, count;
  logic       full, empty, afull, aempty, ovf, udf;

  logic       reset1, wr1, rd1;
  logic [3:0] din1, dout1, count1;
  logic       full1, empty1, afull1, aempty1, ovf1, udf1;

  int         checks;
  int         errors;
  logic [3:0] data_q [$];
  logic       rd_expect;

  sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .Wr_en(wr_en), .Data_in(data_in), .Rd_en(rd_en),
    .Data_out(data_out), .Full(full), .Empty(empty), .Almost_full(afull),
    .Almost_empty(aempty), .Count(count), .Overflow(ovf), .Underflow(udf)
  );

  sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset1), .Wr_en(wr1), .Data_in(din1), .Rd_en(rd1),
    .Data_out(dout1), .Full(full1), .Empty(empty1), .Almost_full(afull1),
    .Almost_empty(aempty1), .Count(count1), .Overflow(ovf1), .Underflow(udf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Flags expected for a given occupancy of the standard instance.
  task automatic chk_state(input string tag, input int c);
    chk({tag, ".count"},  count,  c);
    chk({tag, ".empty"},  empty,  (c == 0));
    chk({tag, ".full"},   full,   (c == 8));
    chk({tag, ".afull"},  afull,  (c >= 6));
    chk({tag, ".aempty"}, aempty, (c <= 2));
  endtask

  // One clock of stimulus; a read that should be accepted pushes its expected word.
  task automatic drive(input logic w, input logic [3:0] d, input logic r,
                       input logic re, input logic [3:0] ev);
    wr_en     = w;
    data_in   = d;
    rd_en     = r;
    rd_expect = re;
    if (re) data_q.push_back(ev);
    step();
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_expect = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    wr_en     = 1'b1;
    rd_en     = 1'b0;
    data_in   = 4'h5;
    rd_expect = 1'b0;
    reset1    = 1'b1;
    wr1       = 1'b0;
    rd1       = 1'b0;
    din1      = 4'h0;

    // Monitor: a read flagged before an edge must show its word right after that edge.
    fork
      begin : monitor
        logic       pend;
        logic [3:0] mexp;
        forever begin
          @(posedge clk);
          pend = rd_expect;
          @(negedge clk);
          if (pend) begin
            checks++;
            if (data_q.size() == 0) begin
              errors++;
              $display("FAIL sb_read: got %0h expected nothing queued", data_out);
            end else begin
              mexp = data_q.pop_front();
              if (data_out !== mexp) begin
                errors++;
                $display("FAIL sb_read: got %0h expected %0h", data_out, mexp);
              end else begin
                $display("ok   sb_read: %0h", data_out);
              end
            end
          end
        end
      end
    join_none

    // Reset held two cycles with a write request pending.
    step();
    step();
    chk_state("reset", 0);
    chk("reset.ovf", ovf, 0);
    chk("reset.dout", data_out, 0);
    reset  = 1'b0;
    reset1 = 1'b0;
    wr_en  = 1'b0;
    step();
    chk("reset.idle_count", count, 0);

    // Fill 0..7, then one rejected write.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0, 4'h0);
      chk_state($sformatf("fill%0d", i), i + 1);
      chk($sformatf("fill%0d.ovf", i), ovf, 0);
    end
    drive(1'b1, 4'h9, 1'b0, 1'b0, 4'h0);
    chk("overflow.pulse", ovf, 1);
    chk("overflow.count", count, 8);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    chk("overflow.clear", ovf, 0);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b1, 4'(i));
      chk_state($sformatf("drain%0d", i), 7 - i);
    end
    drive(1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
    chk("underflow.pulse", udf, 1);
    chk("underflow.empty", empty, 1);
    chk("underflow.hold", data_out, 4'h7);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    chk("underflow.clear", udf, 0);

    // Pointer wrap: five bursts of three writes and three reads.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) drive(1'b1, 4'(r * 3 + k + 1), 1'b0, 1'b0, 4'h0);
      chk($sformatf("wrap%0d.count3", r), count, 3);
      for (int k = 0; k < 3; k++) drive(1'b0, 4'h0, 1'b1, 1'b1, 4'(r * 3 + k + 1));
      chk($sformatf("wrap%0d.count0", r), count, 0);
    end

    // Simultaneous requests at full: read wins, write 0x3 dropped.
    for (int i = 0; i < 8; i++) drive(1'b1, 4'(i + 8), 1'b0, 1'b0, 4'h0);
    chk("simfull.pre", full, 1);
    drive(1'b1, 4'h3, 1'b1, 1'b1, 4'h8);
    chk("simfull.ovf", ovf, 1);
    chk("simfull.count", count, 7);
    chk("simfull.full", full, 0);
    for (int i = 1; i < 8; i++) drive(1'b0, 4'h0, 1'b1, 1'b1, 4'(i + 8));
    chk("simfull.drained", count, 0);

    // Simultaneous requests at empty: write wins, read rejected.
    drive(1'b1, 4'h6, 1'b1, 1'b0, 4'h0);
    chk("simempty.udf", udf, 1);
    chk("simempty.count", count, 1);
    chk("simempty.empty", empty, 0);
    drive(1'b0, 4'h0, 1'b1, 1'b1, 4'h6);
    chk("simempty.count0", count, 0);

    // First-word-fall-through instance.
    wr1 = 1'b1; din1 = 4'hA; step(); wr1 = 1'b0;
    chk("fwft.head", dout1, 4'hA);
    chk("fwft.empty", empty1, 0);
    chk("fwft.count", count1, 1);
    wr1 = 1'b1; din1 = 4'hB; step(); wr1 = 1'b0;
    chk("fwft.head_kept", dout1, 4'hA);
    rd1 = 1'b1; step(); rd1 = 1'b0;
    chk("fwft.pop_next", dout1, 4'hB);
    chk("fwft.pop_count", count1, 1);
    rd1 = 1'b1; step(); rd1 = 1'b0;
    chk("fwft.pop_empty", empty1, 1);
    for (int i = 0; i < 5; i++) begin
      wr1 = 1'b1; din1 = 4'(i + 1); step();
    end
    wr1 = 1'b0;
    chk("fwft.fill5", count1, 5);
    chk("fwft.fill5_ae", aempty1, 0);
    reset1 = 1'b1; step(); reset1 = 1'b0;
    chk("fwft.rst_count", count1, 0);
    chk("fwft.rst_empty", empty1, 1);
    chk("fwft.rst_full", full1, 0);
    chk("fwft.rst_ae", aempty1, 1);

    step();
    step();
    chk("sb.leftover", data_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
